// File: rtl/miriscv_mem_arbiter_if.sv
// Bus bundle between the core's fetch/LSU ports, the arbiter and the RAM.
// The slave modport is the arbiter's view; the master modport is the view of
// the core plus RAM that surround it.
interface miriscv_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              instr_req_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [31:0]       instr_rdata_o;
  logic              instr_err_o;

  logic              data_req_i;
  logic              data_we_i;
  logic [3:0]        data_be_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [31:0]       data_wdata_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic [31:0]       data_rdata_o;
  logic              data_err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/miriscv_mem_arbiter.sv
// Two-master arbiter for the single-port, 1-cycle-latency program/data RAM.
// Fetch and load/store requests are granted combinationally (one per cycle);
// the response is routed back to the winner in the following cycle.
// Out-of-range accesses are granted but never reach the RAM; they return err.
// Optional macro MIRISCV_ARB_RR_EN: round-robin on contention (first contended
// grant goes to DATA). Without it DATA has fixed priority over INSTR.
module miriscv_mem_arbiter #(
  parameter int RAM_SIZE = 512,
  parameter int ADDR_W   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  miriscv_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * RAM_SIZE);

  owner_e            owner_p0, owner_p1;
  logic              err_p0, err_p1;
  logic              we_p0, we_p1;
  logic              prefer_data;
  logic              pick_data, pick_instr;
  logic [ADDR_W-1:0] sel_addr;
  logic              in_range;

`ifdef MIRISCV_ARB_RR_EN
  logic rr_data_q, rr_data_d;

  // Pointer flips only when both masters competed for this cycle's grant.
  always_comb begin
    rr_data_d = rr_data_q;
    if (pick_data && bus.instr_req_i) rr_data_d = 1'b0;
    if (pick_instr && bus.data_req_i) rr_data_d = 1'b1;
  end

  // Round-robin pointer register; 1 = DATA wins the next contention.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rr_data_q <= 1'b1;
    else          rr_data_q <= rr_data_d;
  end

  assign prefer_data = rr_data_q;
`else
  assign prefer_data = 1'b1;
`endif

  // Winner selection; no grant is given while reset is held.
  always_comb begin
    pick_data  = rst_n_i & bus.data_req_i & (~bus.instr_req_i | prefer_data);
    pick_instr = rst_n_i & bus.instr_req_i & ~pick_data;
  end

  assign sel_addr = pick_data ? bus.data_addr_i : bus.instr_addr_i;
  assign in_range = (sel_addr < ADDR_LIMIT);

  // Grant stage (p0): drive RAM port and decide next owner; response stage (p1): route data.
  always_comb begin
    owner_p0        = OWN_NONE;
    err_p0          = 1'b0;
    we_p0           = 1'b0;
    bus.instr_gnt_o = 1'b0;
    bus.data_gnt_o  = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'h0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;

    if (pick_data) begin
      bus.data_gnt_o = 1'b1;
      owner_p0       = OWN_DATA;
      we_p0          = bus.data_we_i;
      err_p0         = ~in_range;
      if (in_range) begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = bus.data_we_i;
        bus.mem_be_o    = bus.data_be_i;
        bus.mem_addr_o  = bus.data_addr_i;
        bus.mem_wdata_o = bus.data_wdata_i;
      end
    end else if (pick_instr) begin
      bus.instr_gnt_o = 1'b1;
      owner_p0        = OWN_INSTR;
      err_p0          = ~in_range;
      if (in_range) begin
        bus.mem_req_o  = 1'b1;
        bus.mem_be_o   = 4'hF;
        bus.mem_addr_o = bus.instr_addr_i;
      end
    end

    bus.instr_rvalid_o = (owner_p1 == OWN_INSTR);
    bus.instr_err_o    = (owner_p1 == OWN_INSTR) & err_p1;
    bus.instr_rdata_o  = ((owner_p1 == OWN_INSTR) && !err_p1) ? bus.mem_rdata_i : 32'h0;
    bus.data_rvalid_o  = (owner_p1 == OWN_DATA);
    bus.data_err_o     = (owner_p1 == OWN_DATA) & err_p1;
    bus.data_rdata_o   = ((owner_p1 == OWN_DATA) && !err_p1 && !we_p1) ? bus.mem_rdata_i : 32'h0;
  end

  // Owner/flag register: remembers who gets the response next cycle; reset drops it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_p1 <= OWN_NONE;
      err_p1   <= 1'b0;
      we_p1    <= 1'b0;
    end else begin
      owner_p1 <= owner_p0;
      err_p1   <= err_p0;
      we_p1    <= we_p0;
    end
  end

endmodule

// File: doc/miriscv_mem_arbiter.md
Name: miriscv_mem_arbiter

Overview:
Two-master arbiter that shares the single-port, 1-cycle-latency program/data RAM inside miriscv_top between the core's instruction-fetch port and its load/store port. It grants one request per cycle, drives the RAM port, and routes the registered read response back to the winning master one cycle later. Out-of-range accesses are trapped here and never reach the RAM.

Parameters:
RAM_SIZE, 512, RAM depth in 32-bit words; legal byte addresses are 0 .. 4*RAM_SIZE-1
ADDR_W, 32, width of byte addresses on all ports

Ports:
clk_i  in  1  system clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request, held until granted
instr_addr_i  in  ADDR_W  fetch byte address
instr_gnt_o  out  1  fetch request accepted this cycle
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch data
instr_err_o  out  1  fetch address out of range, qualified by instr_rvalid_o
data_req_i  in  1  load/store request, held until granted
data_we_i  in  1  1 = store
data_be_i  in  4  store byte enables
data_addr_i  in  ADDR_W  load/store byte address
data_wdata_i  in  32  store data
data_gnt_o  out  1  load/store accepted this cycle
data_rvalid_o  out  1  load/store response valid, including store acknowledge
data_rdata_o  out  32  load data
data_err_o  out  1  load/store address out of range, qualified by data_rvalid_o
mem_req_o  out  1  RAM access strobe
mem_we_o  out  1  RAM write enable
mem_be_o  out  4  RAM byte enables
mem_addr_o  out  ADDR_W  RAM byte address
mem_wdata_o  out  32  RAM write data
mem_rdata_i  in  32  RAM read data, valid the cycle after mem_req_o

Behaviour:
- Clocking and reset: single clock clk_i; reset is asynchronous, active-low on rst_n_i.
- Reset values: all *_gnt_o, *_rvalid_o, *_err_o and mem_req_o/mem_we_o are 0; rdata outputs are 0; the owner register is NONE; the round-robin pointer selects DATA.
- Grant path (combinational from req):
  - At most one grant per cycle.
  - A grant is allowed every cycle, including the cycle in which the previous response returns; the RAM has fixed 1-cycle latency, so pipelined throughput is 1 access/cycle.
- Arbitration when both requests are asserted: see Optional Feature.
- Granted request, address in range:
  - mem_req_o = 1; mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are copied from the winner.
  - A fetch forces we = 0 and be = 4'hF.
- Granted request, address out of range (addr >= 4*RAM_SIZE):
  - gnt is still asserted; mem_req_o = 0.
  - The response carries err = 1 and rdata = 0.
- When nothing is granted: mem_req_o = 0, and the other mem_* outputs are 0.
- Response phase:
  - Registered state: owner in {NONE, INSTR, DATA}, plus err and we flags.
  - In cycle N+1 after a grant in cycle N, exactly one rvalid pulses for one cycle, on the owner's port.
  - rdata = mem_rdata_i for an in-range read; rdata = 0 for a store or an error.
  - The non-owner's rvalid stays 0.
- Misaligned addresses: addr[1:0] is passed through unchanged; alignment checking belongs to the LSU.
- Reset mid-operation: the pending response is discarded; no rvalid follows reset release until a new grant.
- Masters must hold req and payload stable until gnt; the arbiter does not latch payloads.

Optional Feature:
Macro MIRISCV_ARB_RR_EN.
- Defined: round-robin on contention.
  - The pointer flips to the other master after each contended grant.
  - The first contended grant after reset goes to DATA.
  - An uncontended grant does not move the pointer.
- Not defined: fixed priority; DATA always wins over INSTR. The pointer register is not implemented.

Test Plan:
- Reset: hold rst_n_i=0 with both reqs asserted -> all outputs 0; release rst_n_i -> grants start on the same cycle as the release.
- Fetch only: instr_req_i=1, addr 0x10, RAM word 4 = 0x00500093 -> instr_gnt_o=1 in cycle N; instr_rvalid_o=1 with rdata 0x00500093 in cycle N+1; back-to-back fetches get one grant per cycle.
- Store then load: data store at addr 0x100, be=4'b0011, wdata 0xAABBCCDD over old 0x11223344 -> store ack with data_rvalid_o=1, rdata 0; the following load of 0x100 returns 0x1122CCDD.
- Contention, macro off: both reqs held for 4 cycles -> data_gnt_o=1 in all 4 cycles, instr_gnt_o=0; with MIRISCV_ARB_RR_EN -> grant order D,I,D,I.
- Out of range: data load at 0x800 with RAM_SIZE=512 -> gnt=1, mem_req_o=0; next cycle data_rvalid_o=1, data_err_o=1, rdata 0.
- Reset mid-flight: assert rst_n_i low the cycle after a fetch grant -> no instr_rvalid_o after release.
